// File: rtl/striping_pkg.sv
// rtl/striping_pkg.sv - shared definitions for the striping transmitter and its receiver
// Purpose: state encodings, lane slot constants and the default lane width shared by
//          the transmit striper and the un-striping receiver.
// Ports:   none (package).
package striping_pkg;

  // Default lane/data width; the un-striping receiver uses the same value.
  localparam int WIDTH = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Slot pointer values: which lane the next write targets.
  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/striping.sv
// rtl/striping.sv - two-lane transmit word striper (clk_2f stream to two clk_f lanes)
// Purpose: distributes a single word stream alternately onto lane_0 / lane_1. The slot
//          pointer keeps toggling through short gaps so each lane stays phase-locked to
//          clk_f; after IDLE_GAP idle cycles the block returns to IDLE at a pair boundary
//          and the next word realigns onto lane_0.
// Ports:
//   clk_2f   in   1      clock, 2x lane rate
//   reset    in   1      asynchronous active-high reset
//   data_in  in   WIDTH  input word
//   valid_in in   1      data_in valid this cycle
//   lane_0   out  WIDTH  even-slot word (registered)
//   lane_1   out  WIDTH  odd-slot word (registered)
//   valid_0  out  1      lane_0 holds a valid word
//   valid_1  out  1      lane_1 holds a valid word
module striping
  import striping_pkg::*;
#(
  parameter int WIDTH    = striping_pkg::WIDTH,
  parameter int IDLE_GAP = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] lane_0,
  output logic [WIDTH-1:0] lane_1,
  output logic             valid_0,
  output logic             valid_1
);

  localparam int GW = $clog2(IDLE_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(IDLE_GAP);
  localparam logic [GW-1:0] GAP_EXIT = GW'(IDLE_GAP - 1);

  state_t           state, state_nx;
  logic             sel, sel_nx;
  logic [GW-1:0]    gap_cnt, gap_nx, gap_inc;
  logic [WIDTH-1:0] lane_0_nx, lane_1_nx;
  logic             valid_0_nx, valid_1_nx;

  // Saturating idle counter; never wraps back to 0 on a long gap.
  assign gap_inc = (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + 1'b1;

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      sel     <= LANE0;
      gap_cnt <= '0;
      lane_0  <= '0;
      lane_1  <= '0;
      valid_0 <= 1'b0;
      valid_1 <= 1'b0;
    end else begin
      state   <= state_nx;
      sel     <= sel_nx;
      gap_cnt <= gap_nx;
      lane_0  <= lane_0_nx;
      lane_1  <= lane_1_nx;
      valid_0 <= valid_0_nx;
      valid_1 <= valid_1_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    gap_nx     = gap_cnt;
    lane_0_nx  = lane_0;
    lane_1_nx  = lane_1;
    valid_0_nx = valid_0;
    valid_1_nx = valid_1;

    case (state)
      ST_IDLE: begin
        sel_nx     = LANE0;
        valid_0_nx = 1'b0;
        valid_1_nx = 1'b0;
        if (valid_in) begin
          lane_0_nx  = data_in;
          valid_0_nx = 1'b1;
          sel_nx     = LANE1;
          gap_nx     = '0;
          state_nx   = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        // Pointer advances every cycle, valid or not, to hold the clk_f lane phase.
        sel_nx = ~sel;
        if (valid_in) begin
          gap_nx = '0;
          if (sel == LANE0) begin
            lane_0_nx  = data_in;
            valid_0_nx = 1'b1;
          end else begin
            lane_1_nx  = data_in;
            valid_1_nx = 1'b1;
          end
        end else begin
          gap_nx = gap_inc;
          if (sel == LANE0) valid_0_nx = 1'b0;
          else              valid_1_nx = 1'b0;
          // Leave only at a pair boundary so the receiver never sees a split pair.
          if (sel == LANE0 && gap_cnt >= GAP_EXIT) begin
            state_nx = ST_IDLE;
            sel_nx   = LANE0;
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
        sel_nx   = LANE0;
      end
    endcase
  end

endmodule

// File: tb/tb_striping.sv
// tb/tb_striping.sv - directed self-checking bench for striping
module tb_striping;
  import striping_pkg::*;

  logic             clk_2f = 1'b0;
  logic             reset  = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_in = 1'b0;
  logic [WIDTH-1:0] lane_0, lane_1;
  logic             valid_0, valid_1;

  int vectors     = 0;
  int miscompares = 0;

  // Receiver model state: samples lane_0 then lane_1 on alternate cycles.
  logic             rx_on = 1'b0;
  logic             rx_ph = 1'b0;
  logic [WIDTH-1:0] rxq[$];

  striping #(.WIDTH(WIDTH), .IDLE_GAP(4)) dut (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .lane_0  (lane_0),
    .lane_1  (lane_1),
    .valid_0 (valid_0),
    .valid_1 (valid_1)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    #1;
    if (!rx_on && valid_0) begin
      rx_on = 1'b1;
      rx_ph = 1'b0;
    end
    if (rx_on) begin
      if (rx_ph == 1'b0 && valid_0) rxq.push_back(lane_0);
      if (rx_ph == 1'b1 && valid_1) rxq.push_back(lane_1);
      rx_ph = ~rx_ph;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  initial begin
    // 1 reset: async assert with valid_in high
    valid_in = 1'b1;
    data_in  = 32'hDEAD0000;
    #2;
    chk("rst_lane0", lane_0, 32'h0);
    chk("rst_valid0", {31'b0, valid_0}, 32'h0);
    @(negedge clk_2f) reset = 1'b0;
    step(1'b1, 32'hDEAD0001);
    chk("pre_rst_lane0", lane_0, 32'hDEAD0001);
    reset = 1'b1;
    #1;
    chk("async_lane0", lane_0, 32'h0);
    chk("async_valid0", {31'b0, valid_0}, 32'h0);
    @(posedge clk_2f); #1;
    chk("held_rst_lane0", lane_0, 32'h0);
    chk("held_rst_valid0", {31'b0, valid_0}, 32'h0);
    chk("held_rst_valid1", {31'b0, valid_1}, 32'h0);
    @(negedge clk_2f) reset = 1'b0;

    // 2 back-to-back
    step(1'b1, 32'hA0000001);
    chk("b2b1_lane0", lane_0, 32'hA0000001);
    chk("b2b1_v0", {31'b0, valid_0}, 32'h1);
    chk("b2b1_v1", {31'b0, valid_1}, 32'h0);
    step(1'b1, 32'hA0000002);
    chk("b2b2_lane1", lane_1, 32'hA0000002);
    chk("b2b2_v1", {31'b0, valid_1}, 32'h1);
    chk("b2b2_lane0_hold", lane_0, 32'hA0000001);
    step(1'b1, 32'hA0000003);
    chk("b2b3_lane0", lane_0, 32'hA0000003);
    chk("b2b3_lane1_hold", lane_1, 32'hA0000002);
    step(1'b1, 32'hA0000004);
    chk("b2b4_lane1", lane_1, 32'hA0000004);
    chk("b2b4_lane0_hold", lane_0, 32'hA0000003);

    // 3 gap inside stream
    step(1'b1, 32'h11);
    chk("gap_lane0", lane_0, 32'h11);
    step(1'b1, 32'h22);
    chk("gap_lane1", lane_1, 32'h22);
    step(1'b0, 32'h0);
    chk("gap_v0_low", {31'b0, valid_0}, 32'h0);
    chk("gap_lane0_hold", lane_0, 32'h11);
    step(1'b1, 32'h33);
    chk("gap_33_lane1", lane_1, 32'h33);
    chk("gap_33_v1", {31'b0, valid_1}, 32'h1);
    chk("gap_33_v0", {31'b0, valid_0}, 32'h0);

    // 4 return to IDLE and realign
    idle(6);
    chk("idle_v0", {31'b0, valid_0}, 32'h0);
    chk("idle_v1", {31'b0, valid_1}, 32'h0);
    step(1'b1, 32'hBEEF0001);
    chk("realign_lane0", lane_0, 32'hBEEF0001);
    chk("realign_v0", {31'b0, valid_0}, 32'h1);
    chk("realign_v1", {31'b0, valid_1}, 32'h0);
    chk("realign_lane1_hold", lane_1, 32'h33);

    // 5 odd word count (starts from IDLE after the gap)
    idle(6);
    step(1'b1, 32'h1);
    chk("odd1_lane0", lane_0, 32'h1);
    step(1'b1, 32'h2);
    chk("odd2_lane1", lane_1, 32'h2);
    step(1'b1, 32'h3);
    chk("odd3_lane0", lane_0, 32'h3);
    step(1'b0, 32'h0);
    chk("odd_tail_v1", {31'b0, valid_1}, 32'h0);
    chk("odd_tail_v0", {31'b0, valid_0}, 32'h1);
    chk("odd_tail_lane0", lane_0, 32'h3);
    step(1'b0, 32'h0);
    chk("odd_after_v0", {31'b0, valid_0}, 32'h0);

    // 6 reset mid-stream, restart, loopback order
    idle(6);
    step(1'b1, 32'h61);
    step(1'b1, 32'h62);
    chk("mid_lane1", lane_1, 32'h62);
    valid_in = 1'b1;
    data_in  = 32'h63;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_lane0", lane_0, 32'h0);
    chk("mid_rst_lane1", lane_1, 32'h0);
    chk("mid_rst_v0", {31'b0, valid_0}, 32'h0);
    chk("mid_rst_v1", {31'b0, valid_1}, 32'h0);
    @(negedge clk_2f) reset = 1'b0;
    rx_on = 1'b0;
    rxq.delete();
    step(1'b1, 32'h71);
    chk("restart_lane0", lane_0, 32'h71);
    chk("restart_v0", {31'b0, valid_0}, 32'h1);
    step(1'b1, 32'h72);
    step(1'b1, 32'h73);
    step(1'b1, 32'h74);
    idle(2);
    chk("loop_count", rxq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rxq.size()) chk($sformatf("loop_word%0d", i), rxq[i], 32'h71 + i);
      else chk($sformatf("loop_word%0d", i), 32'hXXXXXXXX, 32'h71 + i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
